// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase controller and its time_counter:
// state encoding and default phase times (phase length is TIME+1 cycles).
package traffic_pkg;

    localparam logic [2:0] ST_RED    = 3'd0;
    localparam logic [2:0] ST_GREEN  = 3'd1;
    localparam logic [2:0] ST_YELLOW = 3'd2;
    localparam logic [2:0] ST_FLASH  = 3'd3;
    localparam logic [2:0] ST_FAULT  = 3'd4;

    localparam int GREEN_TIME  = 29;
    localparam int YELLOW_TIME = 4;
    localparam int RED_TIME    = 9;

endpackage

// File: rtl/ped_req_sync.sv
// Pedestrian button synchronizer followed by a rising-edge detector that
// produces a single-cycle request pulse.
module ped_req_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic req_pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) sync_q[gi] <= 1'b0;
                    else        sync_q[gi] <= btn_i;
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) sync_q[gi] <= 1'b0;
                    else        sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= sync_q[SYNC_STAGES-1];
    end

    assign req_pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/traffic_light_fsm.sv
// Intersection phase controller: sequences RED/GREEN/YELLOW from the counter's
// end pulses, adds night flashing, a pedestrian walk phase and a sticky fault.
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FAULT_CHECK_EN = 1,
    parameter int WALK_EN        = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic g_end,
    input  logic y_end,
    input  logic r_end,
    input  logic night_mode,
    input  logic ped_btn,
    output logic fsm_g,
    output logic fsm_y,
    output logic fsm_r,
    output logic lamp_r,
    output logic lamp_y,
    output logic lamp_g,
    output logic walk,
    output logic ped_wait,
    output logic fault
);

    logic [2:0] state_q, state_d;
    logic       blink_q, blink_d;
    logic       ped_pending_q, ped_pending_d;
    logic       walk_phase_q, walk_phase_d;
    logic       req_pulse;
    logic       bad_pulse;
    logic       yellow_to_red;

    generate
        if (WALK_EN != 0) begin : g_walk
            ped_req_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ped_sync (
                .clk         (clk),
                .rst_n       (rst_n),
                .btn_i       (ped_btn),
                .req_pulse_o (req_pulse)
            );
        end else begin : g_no_walk
            assign req_pulse = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RED;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q       <= 1'b0;
            ped_pending_q <= 1'b0;
            walk_phase_q  <= 1'b0;
        end else begin
            blink_q       <= blink_d;
            ped_pending_q <= ped_pending_d;
            walk_phase_q  <= walk_phase_d;
        end
    end

    // Overlapping end pulses, or a pulse for a phase that is not running.
    always_comb begin
        bad_pulse = (g_end & y_end) | (g_end & r_end) | (y_end & r_end)
                  | (g_end & (state_q != ST_GREEN))
                  | (y_end & (state_q != ST_YELLOW))
                  | (r_end & (state_q != ST_RED) & (state_q != ST_FLASH));
    end

    always_comb begin
        state_d = state_q;
        blink_d = blink_q;
        if ((FAULT_CHECK_EN != 0) && (state_q != ST_FAULT) && bad_pulse) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_RED:    if (r_end) state_d = night_mode ? ST_FLASH : ST_GREEN;
                ST_GREEN:  if (g_end) state_d = ST_YELLOW;
                ST_YELLOW: if (y_end) state_d = ST_RED;
                ST_FLASH: begin
                    if (r_end) begin
                        blink_d = ~blink_q;
                        if (!night_mode) begin
                            state_d = ST_RED;
                            blink_d = 1'b0;
                        end
                    end
                end
                ST_FAULT:  state_d = ST_FAULT;
                default:   state_d = ST_RED;
            endcase
        end
    end

    assign yellow_to_red = (state_q == ST_YELLOW) && (state_d == ST_RED);

    // A press landing on the YELLOW->RED edge is kept for the next cycle of phases.
    always_comb begin
        ped_pending_d = ped_pending_q;
        walk_phase_d  = walk_phase_q;
        if (state_q != ST_FAULT) begin
            ped_pending_d = (yellow_to_red ? 1'b0 : ped_pending_q) | req_pulse;
            if (yellow_to_red) walk_phase_d = ped_pending_q;
        end
        if ((state_q == ST_RED) && (state_d != ST_RED)) walk_phase_d = 1'b0;
    end

    always_comb begin
        fsm_g    = (state_q == ST_GREEN);
        fsm_y    = (state_q == ST_YELLOW);
        fsm_r    = (state_q == ST_RED) || (state_q == ST_FLASH);
        lamp_g   = (state_q == ST_GREEN);
        lamp_y   = (state_q == ST_YELLOW) || ((state_q == ST_FLASH) && blink_q);
        lamp_r   = (state_q == ST_RED) || (state_q == ST_FAULT);
        walk     = (WALK_EN != 0) && (state_q == ST_RED) && walk_phase_q;
        ped_wait = (WALK_EN != 0) && ped_pending_q;
        fault    = (state_q == ST_FAULT);
    end

endmodule
